ram_rd: RTL

RAM_RD -- requirements
Module: ram_rd

---
 rtl/ram_rd.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/ram_rd.sv
// Three-state read port over the write-back RAM words and one external input word.
// Build option IO65_SYNC_EN: put IO65_IN through a 2-flop synchronizer (3-cycle pin-to-sample latency).
module ram_rd #(
    parameter logic [7:0] IO_IN_ADDR = 8'h41
) (
    input  logic        CLK_MA,
    input  logic        RST,
    input  logic        RD_REQ,
    input  logic [7:0]  RAM_ADDR,
    input  logic [15:0] RAM_0,
    input  logic [15:0] RAM_1,
    input  logic [15:0] RAM_2,
    input  logic [15:0] RAM_3,
    input  logic [15:0] RAM_4,
    input  logic [15:0] RAM_5,
    input  logic [15:0] RAM_6,
    input  logic [15:0] RAM_7,
    input  logic [15:0] IO65_IN,
    output logic [15:0] RAM_OUT,
    output logic        RD_VALID,
    output logic        RD_BUSY,
    output logic        RD_ERR,
    output logic        IO65_CHG
);

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        LOOKUP = 2'b01,
        RESP   = 2'b10
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   addr_q;
    logic                err_q;
    logic [DATA_W-1:0]   io65_q;
    logic [DATA_W-1:0]   io65_prev;
    logic [DATA_W-1:0]   io65_d;
    logic [DATA_W-1:0]   lut_data;
    logic                lut_err;
    logic                lut_io;
    logic                chg_clr;

`ifdef IO65_SYNC_EN
    logic [DATA_W-1:0]   io65_s1;
    logic [DATA_W-1:0]   io65_s2;

    // Two-flop synchronizer ahead of the sample register
    always_ff @(posedge CLK_MA) begin
        if (RST) begin
            io65_s1 <= '0;
            io65_s2 <= '0;
        end else begin
            io65_s1 <= IO65_IN;
            io65_s2 <= io65_s1;
        end
    end

    assign io65_d = io65_s2;
`else
    assign io65_d = IO65_IN;
`endif

    // RAM words win over the IO address; the IO port only decodes outside 0..7
    assign lut_io  = (addr_q == IO_IN_ADDR) && (addr_q[ADDR_W-1:3] != '0);
    assign chg_clr = (state == RESP) && lut_io;

    always_comb begin
        lut_data = '0;
        lut_err  = 1'b0;
        case (addr_q)
            8'h00:   lut_data = RAM_0;
            8'h01:   lut_data = RAM_1;
            8'h02:   lut_data = RAM_2;
            8'h03:   lut_data = RAM_3;
            8'h04:   lut_data = RAM_4;
            8'h05:   lut_data = RAM_5;
            8'h06:   lut_data = RAM_6;
            8'h07:   lut_data = RAM_7;
            default: begin
                if (lut_io) lut_data = io65_q;
                else        lut_err  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK_MA) begin
        if (RST) begin
            state     <= IDLE;
            addr_q    <= '0;
            err_q     <= 1'b0;
            io65_q    <= '0;
            io65_prev <= '0;
            RAM_OUT   <= '0;
            RD_VALID  <= 1'b0;
            RD_BUSY   <= 1'b0;
            RD_ERR    <= 1'b0;
            IO65_CHG  <= 1'b0;
        end else begin
            RD_VALID <= 1'b0;
            RD_ERR   <= 1'b0;
            io65_q   <= io65_d;

            // Sticky change flag; the clear on an IO read wins over a same-cycle change
            if (chg_clr)
                IO65_CHG <= 1'b0;
            else if ((io65_d != io65_prev) || (io65_q != io65_prev))
                IO65_CHG <= 1'b1;

            case (state)
                IDLE: begin
                    if (RD_REQ) begin
                        addr_q  <= RAM_ADDR;
                        state   <= LOOKUP;
                        RD_BUSY <= 1'b1;
                    end
                end
                LOOKUP: begin
                    RAM_OUT <= lut_data;
                    err_q   <= lut_err;
                    if (lut_io) io65_prev <= io65_q;
                    state   <= RESP;
                end
                RESP: begin
                    RD_VALID <= 1'b1;
                    RD_ERR   <= err_q;
                    RD_BUSY  <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    RD_BUSY <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule
